// File: rtl/simmem_pkg.sv
// Shared types and sizing for the simulated-memory write-response path.
package simmem_pkg;

    localparam int unsigned IdWidth                    = 3;
    localparam int unsigned NumIds                     = 1 << IdWidth;
    localparam int unsigned ContentWidth               = 8;
    localparam int unsigned WriteRespBankTotalCapacity = 32;
    localparam int unsigned WriteRespBankAddrWidth     = $clog2(WriteRespBankTotalCapacity);
    localparam int unsigned WriteRespRelCntWidth       = WriteRespBankAddrWidth + 1;
    localparam int unsigned WriteRespWidth             = IdWidth + ContentWidth;

    typedef logic [IdWidth-1:0]                id_t;
    typedef logic [WriteRespBankAddrWidth-1:0] wresp_addr_t;
    typedef logic [WriteRespRelCntWidth-1:0]   wresp_cnt_t;

    typedef struct packed {
        logic [IdWidth-1:0]      id;
        logic [ContentWidth-1:0] content;
    } wresp_t;

    // Per-slot link to the next response of the same ID.
    typedef struct packed {
        logic [WriteRespBankAddrWidth-1:0] nxt_elem;
    } wresp_metadata_e;

endpackage

// File: rtl/simmem_id_arbiter.sv
// Picks which eligible ID the bank presents on its output.
// SIMMEM_WRESP_BANK_RR_ARB_EN selects round-robin; otherwise lowest eligible ID wins.
// The choice is frozen while the output is stalled (hold).
module simmem_id_arbiter
    import simmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumIds-1:0] elig,
    input  logic              hold,
    output id_t               sel
);

    logic lock_q;
    id_t  sel_q;
    id_t  arb_sel;

`ifdef SIMMEM_WRESP_BANK_RR_ARB_EN
    id_t  last_q;
    id_t  cand;
    logic pop;

    // A pop happens whenever something is valid and the output is not stalled.
    assign pop = (|elig) && !hold;

    // Search from the ID after the last popped one; the last one itself comes last.
    always_comb begin
        arb_sel = '0;
        cand    = '0;
        for (int o = NumIds; o >= 1; o--) begin
            cand = last_q + id_t'(o);
            if (elig[cand]) begin
                arb_sel = cand;
            end
        end
    end

    // Remember the most recently popped ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= sel;
        end
    end
`else
    // Fixed priority: lowest eligible index.
    always_comb begin
        arb_sel = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (elig[i]) begin
                arb_sel = id_t'(i);
            end
        end
    end
`endif

    assign sel = lock_q ? sel_q : arb_sel;

    // Latch the presented ID while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            lock_q <= hold;
            sel_q  <= sel;
        end
    end

endmodule

// File: rtl/simmem_wresp_bank.sv
// Write-response bank: a shared slot RAM threaded as per-ID linked lists.
// Responses of one ID leave in arrival order once released; IDs may overtake each other.
// Optional: SIMMEM_WRESP_BANK_RR_ARB_EN enables round-robin ID arbitration.
module simmem_wresp_bank
    import simmem_pkg::*;
#(
    parameter int unsigned TotalCapacity = WriteRespBankTotalCapacity
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  wresp_t            in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [NumIds-1:0] release_en_i,
    output wresp_t            out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam wresp_cnt_t CntMax = '1;

    wresp_t          data_q [TotalCapacity];
    wresp_metadata_e meta_q [TotalCapacity];

    logic [TotalCapacity-1:0] free_q, free_d;
    wresp_addr_t head_q [NumIds];
    wresp_addr_t head_d [NumIds];
    wresp_addr_t tail_q [NumIds];
    wresp_addr_t tail_d [NumIds];
    wresp_cnt_t  len_q  [NumIds];
    wresp_cnt_t  len_d  [NumIds];
    wresp_cnt_t  rel_q  [NumIds];
    wresp_cnt_t  rel_d  [NumIds];

    logic [NumIds-1:0] elig;
    id_t               sel;
    id_t               push_id;
    wresp_addr_t       push_slot;
    wresp_addr_t       pop_slot;
    logic              push;
    logic              pop;

    // Lowest-index free slot.
    always_comb begin
        push_slot = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                push_slot = wresp_addr_t'(i);
            end
        end
    end

    // An ID may leave when it holds data and has an outstanding release.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NumIds; k++) begin
            elig[k] = (rel_q[k] != '0) && (len_q[k] != '0);
        end
    end

    assign in_ready_o  = |free_q;
    assign out_valid_o = |elig;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign push_id     = in_data_i.id;
    assign pop_slot    = head_q[sel];
    assign out_data_o  = out_valid_o ? data_q[pop_slot] : '0;

    simmem_id_arbiter u_arbiter (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .elig  (elig),
        .hold  (out_valid_o && !out_ready_i),
        .sel   (sel)
    );

    // Next state of the free map and the per-ID list pointers and counters.
    always_comb begin
        free_d = free_q;
        head_d = head_q;
        tail_d = tail_q;
        len_d  = len_q;
        rel_d  = rel_q;
        if (pop) begin
            free_d[pop_slot] = 1'b1;
        end
        if (push) begin
            free_d[push_slot] = 1'b0;
        end
        for (int k = 0; k < NumIds; k++) begin
            logic push_k;
            logic pop_k;
            push_k = push && (push_id == id_t'(k));
            pop_k  = pop && (sel == id_t'(k));
            // A push into an empty list, or one that replaces the only popped entry,
            // makes the new slot the head.
            if (push_k && ((len_q[k] == '0) || (pop_k && (len_q[k] == wresp_cnt_t'(1))))) begin
                head_d[k] = push_slot;
            end else if (pop_k) begin
                head_d[k] = meta_q[head_q[k]].nxt_elem;
            end
            if (push_k) begin
                tail_d[k] = push_slot;
            end
            if (push_k && !pop_k) begin
                len_d[k] = len_q[k] + wresp_cnt_t'(1);
            end else if (pop_k && !push_k) begin
                len_d[k] = len_q[k] - wresp_cnt_t'(1);
            end
            // A release and a pop in the same cycle cancel out.
            if (release_en_i[k] && !pop_k && (rel_q[k] != CntMax)) begin
                rel_d[k] = rel_q[k] + wresp_cnt_t'(1);
            end else if (pop_k && !release_en_i[k]) begin
                rel_d[k] = rel_q[k] - wresp_cnt_t'(1);
            end
        end
    end

    // Control state; reset discards every stored response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= '1;
            for (int k = 0; k < NumIds; k++) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                len_q[k]  <= '0;
                rel_q[k]  <= '0;
            end
        end else begin
            free_q <= free_d;
            head_q <= head_d;
            tail_q <= tail_d;
            len_q  <= len_d;
            rel_q  <= rel_d;
        end
    end

    // Slot payloads and links; only meaningful while the free map marks them used.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[push_slot] <= in_data_i;
            if (len_q[push_id] != '0) begin
                meta_q[tail_q[push_id]].nxt_elem <= push_slot;
            end
        end
    end

endmodule

// File: tb/tb_simmem_wresp_bank.sv
// Directed self-checking bench for simmem_wresp_bank (honours SIMMEM_WRESP_BANK_RR_ARB_EN).
module tb_simmem_wresp_bank;
    import simmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_ni;
    wresp_t            in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NumIds-1:0] release_en;
    wresp_t            out_data;
    logic              out_valid;
    logic              out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    simmem_wresp_bank dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .release_en_i (release_en),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wresp_t mk(input int id, input int c);
        wresp_t r;
        r.id      = id_t'(id);
        r.content = c[ContentWidth-1:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int c);
        in_data  = mk(id, c);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rel(input int id);
        release_en     = '0;
        release_en[id] = 1'b1;
        tick();
        release_en = '0;
    endtask

    task automatic pop_expect(input string tag, input int id, input int c);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(mk(id, c)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #12;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
    endtask

    int exp_id [4];
    int exp_c  [4];

    initial begin
        rst_ni     = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        release_en = '0;
        out_ready  = 1'b0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_free", dut.free_q, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // Single response, released after arrival.
        push(3, 'h11);
        check_eq("t1_no_rel", 32'(out_valid), 32'd0);
        rel(3);
        pop_expect("t1_pop", 3, 'h11);
        check_eq("t1_empty_valid", 32'(out_valid), 32'd0);
        check_eq("t1_free", dut.free_q, 32'hFFFF_FFFF);
        check_eq("t1_len", 32'(dut.len_q[3]), 32'd0);

        // In-order release of one ID in two groups.
        push(5, 'hA);
        push(5, 'hB);
        push(5, 'hC);
        rel(5);
        pop_expect("t2_a", 5, 'hA);
        check_eq("t2_gap", 32'(out_valid), 32'd0);
        rel(5);
        rel(5);
        pop_expect("t2_b", 5, 'hB);
        pop_expect("t2_c", 5, 'hC);
        check_eq("t2_done", 32'(out_valid), 32'd0);

        // Fill every slot, hold a 33rd request, then free slot 0.
        for (int i = 0; i < 32; i++) begin
            push(6, i);
        end
        check_eq("t3_full", 32'(in_ready), 32'd0);
        in_data  = mk(7, 'hEE);
        in_valid = 1'b1;
        tick();
        tick();
        check_eq("t3_held", 32'(dut.len_q[7]), 32'd0);
        release_en    = '0;
        release_en[6] = 1'b1;
        tick();
        release_en = '0;
        check_eq("t3_full_before_pop", 32'(in_ready), 32'd0);
        pop_expect("t3_pop", 6, 0);
        check_eq("t3_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("t3_reuse_slot0", 32'(dut.head_q[7]), 32'd0);
        check_eq("t3_len7", 32'(dut.len_q[7]), 32'd1);
        check_eq("t3_full_again", 32'(in_ready), 32'd0);
        do_reset();

        // Releases ahead of data; pushes overlap pops back-to-back.
        for (int i = 0; i < 4; i++) begin
            rel(2);
        end
        check_eq("t4_no_data", 32'(out_valid), 32'd0);
        check_eq("t4_rel4", 32'(dut.rel_q[2]), 32'd4);
        out_ready = 1'b1;
        in_data   = mk(2, 'h21);
        in_valid  = 1'b1;
        tick();
        check_eq("t4_first_valid", 32'(out_valid), 32'd1);
        check_eq("t4_first_data", 32'(out_data), 32'(mk(2, 'h21)));
        in_data = mk(2, 'h22);
        tick();
        in_valid = 1'b0;
        check_eq("t4_second_valid", 32'(out_valid), 32'd1);
        check_eq("t4_second_data", 32'(out_data), 32'(mk(2, 'h22)));
        tick();
        out_ready = 1'b0;
        check_eq("t4_done", 32'(out_valid), 32'd0);
        check_eq("t4_rel2", 32'(dut.rel_q[2]), 32'd2);
        check_eq("t4_len", 32'(dut.len_q[2]), 32'd0);
        do_reset();

        // Two IDs competing; stall first, then drain.
        push(1, 'h31);
        push(1, 'h32);
        push(4, 'h41);
        push(4, 'h42);
        release_en = NumIds'((1 << 1) | (1 << 4));
        tick();
        tick();
        release_en = '0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t5_stall_valid", 32'(out_valid), 32'd1);
            check_eq("t5_stall_data", 32'(out_data), 32'(mk(1, 'h31)));
            tick();
        end
`ifdef SIMMEM_WRESP_BANK_RR_ARB_EN
        exp_id = '{1, 4, 1, 4};
        exp_c  = '{'h31, 'h41, 'h32, 'h42};
`else
        exp_id = '{1, 1, 4, 4};
        exp_c  = '{'h31, 'h32, 'h41, 'h42};
`endif
        for (int i = 0; i < 4; i++) begin
            pop_expect("t5_order", exp_id[i], exp_c[i]);
        end
        check_eq("t5_done", 32'(out_valid), 32'd0);

        // Asynchronous reset with content stored.
        for (int i = 0; i < 10; i++) begin
            push(0, 'h50 + i);
        end
        rel(0);
        check_eq("t6_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_async_valid", 32'(out_valid), 32'd0);
        check_eq("t6_async_ready", 32'(in_ready), 32'd1);
        check_eq("t6_async_data", 32'(out_data), 32'd0);
        check_eq("t6_async_free", dut.free_q, 32'hFFFF_FFFF);
        check_eq("t6_async_len", 32'(dut.len_q[0]), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        push(0, 'h77);
        rel(0);
        pop_expect("t6_new", 0, 'h77);
        check_eq("t6_only_new", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
